// File: rtl/seq_player.sv
// rtl/seq_player.sv - plays a latched 32-bit seed as up to 16 timed colour steps on four LEDs
module seq_player #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int GAP_CYCLES = 12_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] seed,
  input  logic [4:0]  len,
  output logic [3:0]  led,
  output logic [1:0]  color,
  output logic [3:0]  step,
  output logic        busy,
  output logic        done
);

  localparam int TMAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [31:0]   seed_q;
  logic [4:0]    len_q;
  logic [3:0]    step_q;
  logic [3:0]    led_q;
  logic [1:0]    color_q;
  logic          busy_q;
  logic          done_q;

  // Colour of the following step and end-of-sequence detection, taken from the latched copies
  logic [3:0] step_inc;
  logic [1:0] next_color;
  logic       last_step;
  logic [4:0] len_clamped;

  assign step_inc    = step_q + 4'd1;
  assign next_color  = seed_q[{step_inc, 1'b0} +: 2];
  assign last_step   = ({1'b0, step_q} == (len_q - 5'd1));
  assign len_clamped = (len > 5'd16) ? 5'd16 : len;

  // Playback FSM: ON/GAP timing per step, abort returns to IDLE without a done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      seed_q  <= '0;
      len_q   <= '0;
      step_q  <= '0;
      led_q   <= '0;
      color_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        timer_q <= '0;
        step_q  <= '0;
        led_q   <= '0;
        color_q <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort && (len != 5'd0)) begin
              seed_q  <= seed;
              len_q   <= len_clamped;
              step_q  <= '0;
              timer_q <= '0;
              color_q <= seed[1:0];
              led_q   <= 4'b0001 << seed[1:0];
              busy_q  <= 1'b1;
              state_q <= S_ON;
            end
          end
          S_ON: begin
            if (timer_q == ON_LAST) begin
              timer_q <= '0;
              led_q   <= '0;
              state_q <= S_GAP;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          S_GAP: begin
            if (timer_q == GAP_LAST) begin
              timer_q <= '0;
              if (last_step) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                step_q  <= '0;
                color_q <= '0;
              end else begin
                step_q  <= step_inc;
                color_q <= next_color;
                led_q   <= 4'b0001 << next_color;
                state_q <= S_ON;
              end
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign led   = led_q;
  assign color = color_q;
  assign step  = step_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_player.sv
// tb/tb_seq_player.sv - directed self-checking bench for seq_player (ON=4, GAP=2)
module tb_seq_player;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] seed;
  logic [4:0]  len;
  logic [3:0]  led;
  logic [1:0]  color;
  logic [3:0]  step;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  seq_player #(.ON_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .abort (abort),
    .seed  (seed),
    .len   (len),
    .led   (led),
    .color (color),
    .step  (step),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs e edges after the accepting edge, for n steps of 6 cycles (4 lit, 2 dark)
  task automatic exp_cycle(input string tag, input int e, input logic [31:0] sd, input int n);
    int         s;
    int         r;
    logic [1:0] c;
    logic [3:0] el;
    if (e < n * 6) begin
      s  = e / 6;
      r  = e % 6;
      c  = sd[2*s +: 2];
      el = (r < 4) ? (4'b0001 << c) : 4'b0000;
      chk($sformatf("%s_led_e%0d", tag, e), led, el);
      chk($sformatf("%s_busy_e%0d", tag, e), busy, 1);
      chk($sformatf("%s_done_e%0d", tag, e), done, 0);
      chk($sformatf("%s_step_e%0d", tag, e), step, s);
      chk($sformatf("%s_color_e%0d", tag, e), color, c);
    end else begin
      chk($sformatf("%s_donepulse_e%0d", tag, e), done, 1);
      chk($sformatf("%s_busyatdone_e%0d", tag, e), busy, 0);
      chk($sformatf("%s_ledatdone_e%0d", tag, e), led, 0);
    end
  endtask

  initial begin
    int seen_done;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    seed  = '0;
    len   = '0;
    #2;
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step, 0);
    chk("rst_color", color, 0);
    #20;
    reset = 1'b1;
    tick(2);

    // 1: four distinct colours, done at edge 24
    seed = 32'hE4E4E4E4; len = 5'd4; start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int e = 0; e <= 24; e++) begin
      exp_cycle("t1", e, 32'hE4E4E4E4, 4);
      if (e < 24) tick(1);
    end
    tick(1);
    chk("t1_done_cleared", done, 0);

    // 2a: len=0 start has no effect
    seed = 32'hE4E4E4E4; len = 5'd0; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t2a_busy", busy, 0);
    chk("t2a_led", led, 0);
    tick(3);
    chk("t2a_busy_later", busy, 0);
    chk("t2a_done_later", done, 0);

    // 2b: len=31 clamps to 16 steps, done at edge 96
    seed = 32'hFFFFFFFF; len = 5'd31; start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int e = 0; e <= 96; e++) begin
      exp_cycle("t2b", e, 32'hFFFFFFFF, 16);
      if (e < 96) tick(1);
    end
    tick(2);

    // 3a: abort during GAP of step 0
    seed = 32'hE4E4E4E4; len = 5'd4; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    chk("t3a_in_gap_led", led, 0);
    chk("t3a_in_gap_busy", busy, 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t3a_abort_led", led, 0);
    chk("t3a_abort_busy", busy, 0);
    chk("t3a_abort_step", step, 0);
    chk("t3a_abort_done", done, 0);
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1;
    end
    chk("t3a_no_done_no_busy", seen_done, 0);

    // 3b: abort during ON of step 1 clears step
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    chk("t3b_step1", step, 1);
    chk("t3b_led1", led, 4'b0010);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t3b_abort_step", step, 0);
    chk("t3b_abort_led", led, 0);
    chk("t3b_abort_busy", busy, 0);
    tick(2);

    // 4: seed/len/start changes while busy ignored; start on done cycle accepted
    seed = 32'hE4E4E4E4; len = 5'd4; start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int e = 0; e <= 24; e++) begin
      exp_cycle("t4", e, 32'hE4E4E4E4, 4);
      if (e == 4) begin seed = 32'h0; len = 5'd1; start = 1'b1; end
      if (e == 5) start = 1'b0;
      if (e == 23) begin seed = 32'h00000003; len = 5'd1; end
      if (e == 24) start = 1'b1;
      if (e < 24) tick(1);
    end
    tick(1);
    start = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      exp_cycle("t4b", e, 32'h00000003, 1);
      if (e < 6) tick(1);
    end
    tick(2);

    // 5: asynchronous reset mid-ON
    seed = 32'hE4E4E4E4; len = 5'd4; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    chk("t5_pre_busy", busy, 1);
    chk("t5_pre_led", led, 4'b0001);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_async_led", led, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_step", step, 0);
    chk("t5_async_done", done, 0);
    #2;
    reset = 1'b1;
    tick(3);
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_led", led, 0);
    chk("t5_idle_done", done, 0);

    // 6: start with abort in IDLE stays idle
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_led", led, 0);
    tick(2);
    chk("t6_busy_later", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
